vga_mem_bist: RTL and testbench

- Hardware built-in self-test engine for the vgachargen memory maps: character map, colour map and character TIFF.
- Sequentially writes a selectable data pattern to each enabled memory channel, reads it back and compares. Reports pass/fail plus details of the first error.
- Sits on the system-clock side, muxed in front of the map write/read ports. Used at bring-up and in regression instead of software fill/readback loops.

---
 rtl/vga_mem_bist_if.sv | 26 ++
 rtl/vga_mem_bist.sv | 271 +++++++++++++++++++++++++++
 tb/tb_vga_mem_bist.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_mem_bist_if.sv
// Memory-side bus of the vgachargen map BIST.
// master: driven by the BIST engine (channel select, address, write strobe/data),
//         receives read data from the selected channel.
// slave:  the map mux / memory side.
interface vga_mem_bist_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);
  logic [NUM_CH-1:0]   mem_ch_sel_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic                mem_we_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W-1:0]   mem_rdata_i;

  modport master (
    output mem_ch_sel_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_ch_sel_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/vga_mem_bist.sv
// Built-in self-test for the vgachargen maps (char map, colour map, TIFF).
// For every enabled channel: write a pattern to DEPTH words, read them back and compare.
// Ports:
//   clk_i, rst_i        system clock, synchronous active-low reset
//   start_i             start pulse, sampled only when idle
//   mode_i, ch_mask_i   pattern select and channel mask, latched on start
//   mem                 memory bus (master side)
//   busy_o, done_o      run in progress / one-cycle completion pulse
//   pass_o              result, valid from done_o until the next start
//   fail_ch_o, err_*_o  details of the first mismatch of the run
//   err_cnt_o           saturating mismatch count
module vga_mem_bist #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH       = 600,
  parameter int unsigned ADDR_STEP   = 1,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned STOP_ON_ERR = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [NUM_CH-1:0]      ch_mask_i,
  vga_mem_bist_if.master         mem,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [$clog2(NUM_CH):0] fail_ch_o,
  output logic [ADDR_W-1:0]      err_addr_o,
  output logic [DATA_W-1:0]      err_exp_o,
  output logic [DATA_W-1:0]      err_act_o,
  output logic [15:0]            err_cnt_o
);

  localparam int unsigned CH_IDX_W = $clog2(NUM_CH) + 1;
  // Word counter also serves as the drain counter (up to RD_LATENCY-1 = 3).
  localparam int unsigned CNT_W = ($clog2(DEPTH + 1) > 2) ? $clog2(DEPTH + 1) : 2;

  typedef enum logic [2:0] {StIdle, StSel, StWrite, StRead, StDrain, StDone} state_e;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] mode,
                                                input logic [CNT_W-1:0] k);
    logic [DATA_W-1:0] kx;
    logic [DATA_W-1:0] one;
    kx  = DATA_W'(k);
    one = DATA_W'(1);
    unique case (mode)
      2'd0: pattern = kx;
      2'd1: pattern = {(DATA_W / 8){kx[7:0]}};
      2'd2: pattern = ~kx;
      2'd3: pattern = one << (32'(k) % DATA_W);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [CNT_W-1:0] k);
    word_addr = ADDR_W'(32'(k) * ADDR_STEP);
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic [NUM_CH-1:0]     tested_q, tested_d;
  logic [CH_IDX_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]      k_q, k_d;

  logic [NUM_CH-1:0]     sel_q, sel_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_W/8-1:0]   be_q, be_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [CH_IDX_W-1:0]   fail_ch_q, fail_ch_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
  logic [DATA_W-1:0]     err_exp_q, err_exp_d;
  logic [DATA_W-1:0]     err_act_q, err_act_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  // Expected-data pipeline: one entry per issued read, compared RD_LATENCY cycles later.
  logic                  pv_q    [RD_LATENCY];
  logic [DATA_W-1:0]     pexp_q  [RD_LATENCY];
  logic [ADDR_W-1:0]     paddr_q [RD_LATENCY];

  logic                  mismatch;
  logic                  flush;
  logic [NUM_CH-1:0]     pending;
  logic [CH_IDX_W-1:0]   pick;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    tested_d   = tested_q;
    cur_d      = cur_q;
    k_d        = k_q;
    pass_d     = pass_q;
    fail_ch_d  = fail_ch_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_act_d  = err_act_q;
    err_cnt_d  = err_cnt_q;
    pending    = mask_q & ~tested_q;
    pick       = '0;

    mismatch = ((state_q == StRead) || (state_q == StDrain)) && pv_q[RD_LATENCY-1] &&
               (mem.mem_rdata_i != pexp_q[RD_LATENCY-1]);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d     = mode_i;
          mask_d     = ch_mask_i;
          tested_d   = '0;
          pass_d     = 1'b1;
          fail_ch_d  = '0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_act_d  = '0;
          err_cnt_d  = '0;
          state_d    = StSel;
        end
      end
      StSel: begin
        if (pending == '0) begin
          state_d = StDone;
        end else begin
          // Descending scan so the lowest pending channel wins.
          for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (pending[i]) pick = CH_IDX_W'(i);
          end
          cur_d          = pick;
          tested_d[pick] = 1'b1;
          k_d            = '0;
          state_d        = StWrite;
        end
      end
      StWrite: begin
        if (k_q == CNT_W'(DEPTH - 1)) begin
          k_d     = '0;
          state_d = StRead;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StRead: begin
        if (k_q == CNT_W'(DEPTH - 1)) begin
          k_d     = '0;
          state_d = StDrain;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        if (k_q == CNT_W'(RD_LATENCY - 1)) begin
          k_d     = '0;
          state_d = StSel;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      // pass_q still high means this is the first mismatch of the run.
      if (pass_q) begin
        fail_ch_d  = cur_q;
        err_addr_d = paddr_q[RD_LATENCY-1];
        err_exp_d  = pexp_q[RD_LATENCY-1];
        err_act_d  = mem.mem_rdata_i;
        pass_d     = 1'b0;
      end
      if (STOP_ON_ERR != 0) state_d = StDone;
    end

    // Outputs are registered, so they are decoded from the next state.
    busy_d  = (state_d != StIdle) && (state_d != StDone);
    done_d  = (state_d == StDone);
    we_d    = (state_d == StWrite);
    be_d    = we_d ? '1 : '0;
    wdata_d = we_d ? pattern(mode_d, k_d) : '0;
    addr_d  = ((state_d == StWrite) || (state_d == StRead)) ? word_addr(k_d) : '0;
    sel_d   = ((state_d == StWrite) || (state_d == StRead) || (state_d == StDrain)) ?
              (NUM_CH'(1) << cur_d) : '0;
    flush   = (state_d == StDone);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      mask_q     <= '0;
      tested_q   <= '0;
      cur_q      <= '0;
      k_q        <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b1;
      fail_ch_q  <= '0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      tested_q   <= tested_d;
      cur_q      <= cur_d;
      k_q        <= k_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_ch_q  <= fail_ch_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_act_q  <= err_act_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Stage 0 captures the word whose address is on the bus this cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        pv_q[i]    <= 1'b0;
        pexp_q[i]  <= '0;
        paddr_q[i] <= '0;
      end
    end else begin
      pv_q[0]    <= (state_q == StRead);
      pexp_q[0]  <= pattern(mode_q, k_q);
      paddr_q[0] <= word_addr(k_q);
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pv_q[i]    <= pv_q[i-1];
        pexp_q[i]  <= pexp_q[i-1];
        paddr_q[i] <= paddr_q[i-1];
      end
    end
  end

  assign mem.mem_ch_sel_o = sel_q;
  assign mem.mem_addr_o   = addr_q;
  assign mem.mem_we_o     = we_q;
  assign mem.mem_be_o     = be_q;
  assign mem.mem_wdata_o  = wdata_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign fail_ch_o        = fail_ch_q;
  assign err_addr_o       = err_addr_q;
  assign err_exp_o        = err_exp_q;
  assign err_act_o        = err_act_q;
  assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_vga_mem_bist.sv
// Bench for vga_mem_bist. Three instances:
//   dut0: defaults (DEPTH 600, step 1, latency 1, stop on error)
//   dut1: as dut0 but runs to completion on error
//   dut2: DEPTH 256, ADDR_STEP 4, RD_LATENCY 3
// Each has a behavioural memory with selectable read latency and an optional bit-0 fault
// on channel 1. Runs push an expected result into a per-instance queue; a monitor pops it
// on done and compares result fields, run length and write-bus sums.
module tb_vga_mem_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        pass;
    logic [2:0]  ch;
    logic [9:0]  addr;
    logic [31:0] ex;
    logic [31:0] ac;
    logic [15:0] cnt;
    int unsigned lat;
    int unsigned nwr;
    int unsigned nch2;
    logic [63:0] dsum;
    logic [63:0] asum;
    int unsigned t0;
  } exp_t;

  exp_t sbq [3][$];

  logic        rst_n [3];
  logic        start [3];
  logic [1:0]  mode  [3];
  logic [2:0]  mask  [3];
  logic        busy  [3];
  logic        done  [3];
  logic        pass  [3];
  logic [2:0]  fch   [3];
  logic [9:0]  eaddr [3];
  logic [31:0] eexp  [3];
  logic [31:0] eact  [3];
  logic [15:0] ecnt  [3];

  // Memory model controls.
  int unsigned mlat     [3];
  logic        flt_on   [3];
  logic        flt_all  [3];
  logic        flt_val  [3];

  // Write-bus statistics per run.
  int unsigned nwr  [3];
  int unsigned nch2 [3];
  logic [63:0] dsum [3];
  logic [63:0] asum [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic string nm(input int g, input string s);
    return $sformatf("dut%0d %s", g, s);
  endfunction

  function automatic int chidx(input logic [2:0] s);
    return s[2] ? 2 : (s[1] ? 1 : 0);
  endfunction

  // Bit-0 fault on channel 1: either every word or only address 2.
  function automatic logic [31:0] flt(input int g, input int c, input logic [9:0] a,
                                      input logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (flt_on[g] && c == 1 && (flt_all[g] || a == 10'd2)) r[0] = flt_val[g];
    return r;
  endfunction

  function automatic exp_t mk(input logic p, input logic [2:0] ch, input logic [9:0] ad,
                              input logic [31:0] ex, input logic [31:0] ac,
                              input logic [15:0] cnt, input int unsigned lat,
                              input int unsigned nw, input int unsigned n2,
                              input logic [63:0] ds, input logic [63:0] as);
    exp_t e;
    e.pass = p;    e.ch = ch;   e.addr = ad; e.ex = ex;   e.ac = ac;  e.cnt = cnt;
    e.lat  = lat;  e.nwr = nw;  e.nch2 = n2; e.dsum = ds; e.asum = as; e.t0 = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DEP  = (g == 2) ? 256 : 600;
    localparam int unsigned STEP = (g == 2) ? 4 : 1;
    localparam int unsigned LAT  = (g == 2) ? 3 : 1;
    localparam int unsigned SOE  = (g == 1) ? 0 : 1;

    vga_mem_bist_if #(.NUM_CH(3), .DATA_W(32), .ADDR_W(10)) bus ();

    vga_mem_bist #(
      .NUM_CH(3), .DATA_W(32), .ADDR_W(10), .DEPTH(DEP), .ADDR_STEP(STEP),
      .RD_LATENCY(LAT), .STOP_ON_ERR(SOE)
    ) dut (
      .clk_i(clk), .rst_i(rst_n[g]), .start_i(start[g]), .mode_i(mode[g]),
      .ch_mask_i(mask[g]), .mem(bus.master), .busy_o(busy[g]), .done_o(done[g]),
      .pass_o(pass[g]), .fail_ch_o(fch[g]), .err_addr_o(eaddr[g]), .err_exp_o(eexp[g]),
      .err_act_o(eact[g]), .err_cnt_o(ecnt[g])
    );

    logic [31:0] mem [3][1024];
    logic [31:0] rd  [4];

    always @(posedge clk) begin
      if (bus.mem_we_o) mem[chidx(bus.mem_ch_sel_o)][bus.mem_addr_o] <= bus.mem_wdata_o;
      rd[0] <= flt(g, chidx(bus.mem_ch_sel_o), bus.mem_addr_o,
                   mem[chidx(bus.mem_ch_sel_o)][bus.mem_addr_o]);
      for (int i = 1; i < 4; i++) rd[i] <= rd[i-1];
    end

    assign bus.mem_rdata_i = rd[mlat[g] - 1];

    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk);
        if (bus.mem_we_o) begin
          nwr[g]++;
          dsum[g] += 64'(bus.mem_wdata_o);
          asum[g] += 64'(bus.mem_addr_o);
          if (mode[g] == 2'd1 && bus.mem_addr_o == 10'd20) begin
            chk(nm(g, "word5 data"), bus.mem_wdata_o, 32'h05050505);
            chk(nm(g, "word5 be"), bus.mem_be_o, 4'hF);
          end
          if (mode[g] == 2'd1 && bus.mem_addr_o == 10'd1020)
            chk(nm(g, "word255 data"), bus.mem_wdata_o, 32'hFFFFFFFF);
        end
        if (bus.mem_ch_sel_o[2]) nch2[g]++;
        if (done[g]) begin
          if (sbq[g].size() == 0) begin
            chk(nm(g, "unexpected done"), done[g], 1'b0);
          end else begin
            e = sbq[g].pop_front();
            chk(nm(g, "pass"), pass[g], e.pass);
            chk(nm(g, "fail_ch"), fch[g], e.ch);
            chk(nm(g, "err_addr"), eaddr[g], e.addr);
            chk(nm(g, "err_exp"), eexp[g], e.ex);
            chk(nm(g, "err_act"), eact[g], e.ac);
            chk(nm(g, "err_cnt"), ecnt[g], e.cnt);
            chk(nm(g, "cycles"), 64'(cyc - e.t0), 64'(e.lat));
            chk(nm(g, "writes"), 64'(nwr[g]), 64'(e.nwr));
            chk(nm(g, "ch2 cycles"), 64'(nch2[g]), 64'(e.nch2));
            chk(nm(g, "wdata sum"), dsum[g], e.dsum);
            chk(nm(g, "waddr sum"), asum[g], e.asum);
          end
        end
      end
    end
  end

  task automatic pulse(input int g, input logic [1:0] m, input logic [2:0] k);
    @(negedge clk);
    mode[g]  = m;
    mask[g]  = k;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic run(input int g, input logic [1:0] m, input logic [2:0] k, input exp_t e);
    @(negedge clk);
    nwr[g] = 0; nch2[g] = 0; dsum[g] = '0; asum[g] = '0;
    mode[g]  = m;
    mask[g]  = k;
    start[g] = 1'b1;
    e.t0     = cyc;
    sbq[g].push_back(e);
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_empty(input int g);
    int n;
    n = 0;
    while (sbq[g].size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(nm(g, "done seen"), 64'(sbq[g].size()), 64'd0);
    sbq[g].delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst_n[g] = 1'b0; start[g] = 1'b0; mode[g] = '0; mask[g] = '0;
      flt_on[g] = 1'b0; flt_all[g] = 1'b0; flt_val[g] = 1'b0;
      nwr[g] = 0; nch2[g] = 0; dsum[g] = '0; asum[g] = '0;
    end
    mlat[0] = 1; mlat[1] = 1; mlat[2] = 3;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
    @(negedge clk);

    // Reset values.
    for (int g = 0; g < 3; g++) begin
      chk(nm(g, "reset pass"), pass[g], 1'b1);
      chk(nm(g, "reset busy"), busy[g], 1'b0);
      chk(nm(g, "reset err_cnt"), ecnt[g], 16'd0);
    end
    chk("dut0 reset done", done[0], 1'b0);
    chk("dut0 reset we", g_dut[0].bus.mem_we_o, 1'b0);
    chk("dut0 reset ch_sel", g_dut[0].bus.mem_ch_sel_o, 3'b000);
    chk("dut0 reset err_addr", eaddr[0], 10'd0);

    // Empty mask: SEL then DONE.
    run(0, 2'd0, 3'b000, mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 64'd0, 64'd0));
    wait_empty(0);

    // All channels, counting pattern, ideal memory: 3 * (1 + 1200 + 1) + 2 cycles.
    run(0, 2'd0, 3'b111, mk(1, 0, 0, 0, 0, 0, 3608, 1800, 1201, 64'd539100, 64'd539100));
    wait_empty(0);

    // Bit 0 stuck at 1 on ch1 word 2: abort after compare of that word, ch2 untouched.
    flt_on[0] = 1'b1; flt_all[0] = 1'b0; flt_val[0] = 1'b1;
    run(0, 2'd0, 3'b111, mk(0, 1, 2, 2, 3, 1, 1808, 1200, 0, 64'd359400, 64'd359400));
    wait_empty(0);
    flt_on[0] = 1'b0;

    // Reset for one cycle in the middle of the ch0 write phase.
    pulse(0, 2'd0, 3'b111);
    repeat (50) @(negedge clk);
    chk("dut0 we before reset", g_dut[0].bus.mem_we_o, 1'b1);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    chk("dut0 we after reset", g_dut[0].bus.mem_we_o, 1'b0);
    chk("dut0 busy after reset", busy[0], 1'b0);
    chk("dut0 pass after reset", pass[0], 1'b1);
    chk("dut0 ch_sel after reset", g_dut[0].bus.mem_ch_sel_o, 3'b000);
    chk("dut0 addr after reset", g_dut[0].bus.mem_addr_o, 10'd0);
    chk("dut0 done after reset", done[0], 1'b0);

    // Fresh run; a second start while busy must not change mode, mask or timing.
    run(0, 2'd0, 3'b111, mk(1, 0, 0, 0, 0, 0, 3608, 1800, 1201, 64'd539100, 64'd539100));
    repeat (100) @(negedge clk);
    pulse(0, 2'd2, 3'b001);
    wait_empty(0);

    // Run-to-completion: bit 0 stuck at 0 on every ch1 word, inverted pattern.
    // ~k has bit 0 set for the 300 even k; the first one is word 0.
    flt_on[1] = 1'b1; flt_all[1] = 1'b1; flt_val[1] = 1'b0;
    run(1, 2'd2, 3'b111, mk(0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 300, 3608, 1800, 1201,
                            64'd7730940591900, 64'd539100));
    wait_empty(1);

    // Byte-addressed channel 2 only, replicated-byte pattern: 1 + 512 + 3 + 2 cycles.
    run(2, 2'd1, 3'b100, mk(1, 0, 0, 0, 0, 0, 518, 256, 515, 64'd549755813760, 64'd130560));
    wait_empty(2);

    // Walking one with a matching 3-cycle memory.
    run(2, 2'd3, 3'b111, mk(1, 0, 0, 0, 0, 0, 1550, 768, 515,
                            64'd103079215080, 64'd391680));
    wait_empty(2);

    // 2-cycle memory behind a 3-cycle compare: word 0 sees word 1's data.
    mlat[2] = 2;
    run(2, 2'd3, 3'b111, mk(0, 0, 0, 32'h1, 32'h2, 1, 262, 256, 0,
                            64'd34359738360, 64'd130560));
    wait_empty(2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
